// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control sequencer for the multi-cycle MIPS datapath. It steps each
// instruction through fetch, decode and the execution states for its class,
// and drives the PC, IR, register-file, ALU-mux and memory controls every
// cycle. FETCH, MEMRD and MEMWR stall on mem_ready so the unified memory may
// take any number of cycles.
//
// Supported opcodes: R-type, j, beq, bne, addi, andi, lw, sw. An unsupported
// opcode pulses illegal_op in DECODE and the instruction retires as a nop.
//
// Ports
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous, active-high reset (forces IDLE)
//   opcode     in   IR[31:26], valid from the cycle after IRWrite
//   mem_ready  in   memory access completes this cycle
//   PCWrite    out  unconditional PC load
//   BeqSig     out  PC load if ALU zero
//   BneSig     out  PC load if ALU not zero
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead    out  memory read request
//   MemWrite   out  memory write request
//   IRWrite    out  instruction register load
//   MemtoReg   out  write-back data select: 1 = MDR
//   RegDst     out  destination register select: 1 = rd
//   RegWrite   out  register-file write
//   ALUSrcA    out  ALU A select: 0 = PC, 1 = rs
//   ALUSrcB    out  ALU B select: 00 rt, 01 4, 10 imm, 11 imm << 2
//   ALUOp      out  000 add, 001 sub, 010 funct, 011 addi, 100 andi
//   PCSource   out  00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op out  one-cycle pulse on an unsupported opcode
//   state_out  out  current state code, zero-extended to STATE_W (>= 4)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               BeqSig,
  output logic               BneSig,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q;
  state_e state_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before the case so every path drives state_d;
    // a missing branch would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_J:             state_d = S_JUMP;
          // Unsupported opcode retires as a nop; PC already advanced in FETCH.
          default:          state_d = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything that is not lw is a store.
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      // Codes 13..15 are unused and recover through IDLE.
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register. Reset is asynchronous so a reset in the middle of a
  // memory wait drops every request before the next edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. IRWrite/PCWrite in FETCH follow mem_ready in the same
  // cycle, and illegal_op/branch/ALUOp follow the opcode that is only valid
  // from DECODE onward, so the controls are decoded from the current state
  // rather than registered one cycle ahead.
  // -------------------------------------------------------------------------
  always_comb begin
    PCWrite    = 1'b0;
    BeqSig     = 1'b0;
    BneSig     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    PCSource   = 2'b00;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC + 4 and the instruction word commit only on the completing cycle.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        // Branch target PC + (imm << 2) is computed speculatively into ALUOut.
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ANDI, OP_LW, OP_SW: illegal_op = 1'b0;
          default:                        illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        BeqSig   = (opcode == OP_BEQ);
        BneSig   = (opcode == OP_BNE);
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_ANDI) ? 3'b100 : 3'b011;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: begin
        // IDLE and unused codes drive every control low.
      end
    endcase
  end

  // Zero-extend the 4-bit state code onto the debug port.
  always_comb begin
    state_out      = '0;
    state_out[3:0] = state_q;
  end

  // -------------------------------------------------------------------------
  // Structural invariants of the control word.
  // -------------------------------------------------------------------------
  a_mem_excl: assert property (@(posedge clk) disable iff (reset)
    !(MemRead && MemWrite));
  a_write_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({RegWrite, PCWrite, MemWrite}));
  a_branch_excl: assert property (@(posedge clk) disable iff (reset)
    !(BeqSig && BneSig));

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. A behavioural model tracks which
// state each instruction must be in as a queue of remaining steps for its
// class, and a table of the control word for each step. One compare process
// checks every DUT output against the model on each falling edge; directed
// checks pin cycle counts, state sequences and particular control fields.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, BeqSig, BneSig, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state_out;

  ctrl_t dut_c;

  int errors = 0;
  int checks = 0;

  // Model state and observation records.
  int    m_state = 0;
  int    plan[$];
  logic [7:0] trace[$];  // {illegal_op, IorD, RegWrite, MemtoReg, state[3:0]}
  ctrl_t snap[16];       // last control word seen in each state code
  int    rw_cnt  = 0;
  int    ill_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .BeqSig    (BeqSig),
    .BneSig    (BneSig),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .MemtoReg  (MemtoReg),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSource  (PCSource),
    .illegal_op(illegal_op),
    .state_out (state_out)
  );

  assign dut_c = {PCWrite, BeqSig, BneSig, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, illegal_op};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word each step must present, straight from the step descriptions.
  function automatic ctrl_t expect_ctrl(input int st, input logic [5:0] op,
                                        input logic mr);
    ctrl_t c = '0;
    case (st)
      1: begin
        c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = mr;   c.pc_write  = mr;
      end
      2: begin
        c.alu_src_b = 2'b11;
        c.illegal = !(op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
                                 OP_ANDI, OP_LW, OP_SW});
      end
      3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      5:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      6:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      7:  begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      8:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      9: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'b01;
        c.beq = (op == OP_BEQ); c.bne = (op == OP_BNE);
      end
      10: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = (op == OP_ANDI) ? 3'b100 : 3'b011;
      end
      11: c.reg_write = 1'b1;
      12: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Model: once FETCH completes, the instruction's remaining steps are queued
  // by class; the memory steps hold while mem_ready is low; an empty queue
  // means the next instruction is fetched.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_state = 0;
      plan.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (mem_ready) begin
        case (opcode)
          OP_LW:            plan = '{2, 3, 4, 5};
          OP_SW:            plan = '{2, 3, 6};
          OP_R:             plan = '{2, 7, 8};
          OP_BEQ, OP_BNE:   plan = '{2, 9};
          OP_ADDI, OP_ANDI: plan = '{2, 10, 11};
          OP_J:             plan = '{2, 12};
          default:          plan = '{2};
        endcase
        m_state = plan.pop_front();
      end
    end else if ((m_state == 4 || m_state == 6) && !mem_ready) begin
      m_state = m_state;
    end else begin
      m_state = (plan.size() > 0) ? plan.pop_front() : 1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    @(negedge clk);
    check("ctrl", dut_c, expect_ctrl(m_state, opcode, mem_ready));
    check("state_out", state_out, m_state);
    trace.push_back({illegal_op, IorD, RegWrite, MemtoReg, state_out});
    snap[state_out] = dut_c;
    rw_cnt  += int'(RegWrite);
    ill_cnt += int'(illegal_op);
  end

  task automatic tick(input logic mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to the next FETCH, stalling the
  // fetch and the data access by the given number of wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fetch_wait,
                           input int mem_wait, output int cycles);
    int  fw = fetch_wait;
    int  mw = mem_wait;
    bit  left = 1'b0;
    bit  done = 1'b0;
    opcode = op;
    cycles = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (m_state == 1) begin
        mem_ready = (fw == 0);
        if (fw > 0) fw--;
      end else if (m_state == 4 || m_state == 6) begin
        mem_ready = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      cycles++;
      if (m_state != 1) left = 1'b1;
      else if (left) done = 1'b1;
    end
    if (!done) check("instr_timeout", 32'd1, 32'd0);
  endtask

  int cyc;
  int n;
  int exp_lw0[6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h44, 8'h35};
  int exp_ra[8]  = '{1, 2, 7, 8, 1, 2, 10, 11};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ctrl", dut_c, 32'd0);
    check("reset_state", state_out, 32'd0);

    // lw, zero-wait memory: 0,1,2,3,4,5 then back to 1.
    trace.delete();
    tick(1'b1);
    run_instr(OP_LW, 0, 0, cyc);
    check("lw0_cycles", cyc, 5);
    check("lw0_len", trace.size(), 6);
    for (int i = 0; i < 6 && i < trace.size(); i++)
      check($sformatf("lw0_trace%0d", i), trace[i], exp_lw0[i]);
    check("lw0_end_state", state_out, 1);

    // lw with three wait cycles in MEMRD.
    trace.delete();
    rw_cnt = 0;
    run_instr(OP_LW, 0, 3, cyc);
    check("lw_wait_cycles", cyc, 8);
    n = 0;
    foreach (trace[i]) if (trace[i] == 8'h44) n++;
    check("lw_memrd_held", n, 4);
    check("lw_wait_rw_pulses", rw_cnt, 1);

    // sw with one fetch wait and two write waits.
    run_instr(OP_SW, 1, 2, cyc);
    check("sw_cycles", cyc, 7);

    // beq then bne.
    run_instr(OP_BEQ, 0, 0, cyc);
    check("beq_cycles", cyc, 3);
    check("beq_beqsig", snap[9].beq, 1);
    check("beq_bnesig", snap[9].bne, 0);
    run_instr(OP_BNE, 0, 0, cyc);
    check("bne_cycles", cyc, 3);
    check("bne_bnesig", snap[9].bne, 1);
    check("bne_beqsig", snap[9].beq, 0);
    check("bne_aluop", snap[9].alu_op, 3'b001);
    check("bne_pcsource", snap[9].pc_source, 2'b01);

    // R-type then andi back-to-back.
    trace.delete();
    run_instr(OP_R, 0, 0, cyc);
    check("r_cycles", cyc, 4);
    run_instr(OP_ANDI, 0, 0, cyc);
    check("andi_cycles", cyc, 4);
    check("ra_len", trace.size(), 8);
    for (int i = 0; i < 8 && i < trace.size(); i++)
      check($sformatf("ra_state%0d", i), trace[i][3:0], exp_ra[i]);
    check("rwb_regdst", snap[8].reg_dst, 1);
    check("andi_aluop", snap[10].alu_op, 3'b100);

    // addi with two fetch waits; jump.
    run_instr(OP_ADDI, 2, 0, cyc);
    check("addi_cycles", cyc, 6);
    check("addi_aluop", snap[10].alu_op, 3'b011);
    run_instr(OP_J, 0, 0, cyc);
    check("j_cycles", cyc, 3);
    check("j_pcsource", snap[12].pc_source, 2'b10);

    // Unsupported opcode: one illegal_op pulse in DECODE, then FETCH.
    trace.delete();
    ill_cnt = 0;
    rw_cnt  = 0;
    run_instr(OP_BAD, 0, 0, cyc);
    check("ill_cycles", cyc, 2);
    check("ill_pulses", ill_cnt, 1);
    check("ill_rw", rw_cnt, 0);
    if (trace.size() >= 2) check("ill_decode", trace[1], 8'h82);
    else check("ill_trace_len", trace.size(), 2);
    check("ill_next_state", state_out, 1);

    // Reset during a stalled store aborts it asynchronously.
    opcode = OP_SW;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    #2;
    check("abort_pre_memwrite", MemWrite, 1);
    check("abort_pre_state", state_out, 6);
    reset = 1'b1;
    #1;
    check("abort_memwrite", MemWrite, 0);
    check("abort_state", state_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_idle", state_out, 0);
    tick(1'b0);
    check("abort_fetch", state_out, 1);

    // Recovery after the abort.
    run_instr(OP_LW, 0, 1, cyc);
    check("post_abort_lw_cycles", cyc, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
